framebuffer_writer: RTL



---
 rtl/framebuffer_writer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/framebuffer_writer.sv
// Writes a raster-order 4-bit pixel stream into the back half of a double-buffered BRAM,
// and swaps front/back on the first vsync falling edge after a complete frame.
module framebuffer_writer #(
   parameter int WIDTH     = 320,
   parameter int HEIGHT    = 240,
   parameter int ADDR_BITS = 18
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 pixel_valid_in,
   input  logic [3:0]           pixel_data_in,
   input  logic                 pixel_sof_in,
   output logic                 pixel_ready_out,
   input  logic                 vsync_in,
   output logic                 bram_we_out,
   output logic [ADDR_BITS-1:0] bram_addr_out,
   output logic [3:0]           bram_data_out,
   output logic                 front_buf_out,
   output logic                 frame_done_out,
   output logic                 swap_out,
   output logic                 resync_out,
   output logic [15:0]          frame_count_out
);

   localparam int IDX_BITS = ADDR_BITS - 1;
   localparam logic [IDX_BITS-1:0] X_LAST = IDX_BITS'(WIDTH - 1);
   localparam logic [IDX_BITS-1:0] Y_LAST = IDX_BITS'(HEIGHT - 1);
   localparam logic [IDX_BITS-1:0] W_STEP = IDX_BITS'(WIDTH);

   typedef enum logic {
      S_WRITE,
      S_WAIT_SWAP
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_BITS-1:0]   x_q, x_d;
   logic [IDX_BITS-1:0]   y_q, y_d;
   logic [IDX_BITS-1:0]   row_base_q, row_base_d;
   logic                  back_buf_q, back_buf_d;
   logic                  front_buf_q, front_buf_d;
   logic                  we_q, we_d;
   logic [ADDR_BITS-1:0]  addr_q, addr_d;
   logic [3:0]            data_q, data_d;
   logic                  frame_done_q, frame_done_d;
   logic                  swap_q, swap_d;
   logic                  resync_q, resync_d;
   logic [15:0]           frame_count_q, frame_count_d;
   logic                  vsync_prev_q, vsync_prev_d;

   logic                  xfer;
   logic                  vsync_fall;
   logic                  resync;
   logic [IDX_BITS-1:0]   cur_x, cur_y, cur_row;

   assign pixel_ready_out = rst_n_in && (state_q == S_WRITE);
   assign xfer            = pixel_valid_in && pixel_ready_out;
   assign vsync_fall      = vsync_prev_q && !vsync_in;

   always_comb begin
      state_d       = state_q;
      x_d           = x_q;
      y_d           = y_q;
      row_base_d    = row_base_q;
      back_buf_d    = back_buf_q;
      front_buf_d   = front_buf_q;
      we_d          = 1'b0;
      addr_d        = addr_q;
      data_d        = data_q;
      frame_done_d  = 1'b0;
      swap_d        = 1'b0;
      resync_d      = 1'b0;
      frame_count_d = frame_count_q;
      vsync_prev_d  = vsync_in;
      resync        = 1'b0;
      cur_x         = x_q;
      cur_y         = y_q;
      cur_row       = row_base_q;

      if (state_q == S_WRITE) begin
         if (xfer) begin
            // A stray SOF restarts the raster at pixel 0, then advances normally from there.
            resync = pixel_sof_in && ((x_q != '0) || (y_q != '0));
            if (resync) begin
               cur_x   = '0;
               cur_y   = '0;
               cur_row = '0;
            end
            we_d     = 1'b1;
            addr_d   = {back_buf_q, cur_row + cur_x};
            data_d   = pixel_data_in;
            resync_d = resync;
            if (cur_x == X_LAST) begin
               x_d = '0;
               if (cur_y == Y_LAST) begin
                  y_d          = '0;
                  row_base_d   = '0;
                  frame_done_d = 1'b1;
                  state_d      = S_WAIT_SWAP;
               end else begin
                  y_d        = cur_y + 1'b1;
                  row_base_d = cur_row + W_STEP;
               end
            end else begin
               x_d        = cur_x + 1'b1;
               y_d        = cur_y;
               row_base_d = cur_row;
            end
         end
      end else if (vsync_fall) begin
         front_buf_d   = back_buf_q;
         back_buf_d    = ~back_buf_q;
         swap_d        = 1'b1;
         frame_count_d = frame_count_q + 16'd1;
         state_d       = S_WRITE;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q       <= S_WRITE;
         x_q           <= '0;
         y_q           <= '0;
         row_base_q    <= '0;
         back_buf_q    <= 1'b1;
         front_buf_q   <= 1'b0;
         we_q          <= 1'b0;
         addr_q        <= '0;
         data_q        <= '0;
         frame_done_q  <= 1'b0;
         swap_q        <= 1'b0;
         resync_q      <= 1'b0;
         frame_count_q <= '0;
         vsync_prev_q  <= 1'b1;
      end else begin
         state_q       <= state_d;
         x_q           <= x_d;
         y_q           <= y_d;
         row_base_q    <= row_base_d;
         back_buf_q    <= back_buf_d;
         front_buf_q   <= front_buf_d;
         we_q          <= we_d;
         addr_q        <= addr_d;
         data_q        <= data_d;
         frame_done_q  <= frame_done_d;
         swap_q        <= swap_d;
         resync_q      <= resync_d;
         frame_count_q <= frame_count_d;
         vsync_prev_q  <= vsync_prev_d;
      end
   end

   assign bram_we_out     = we_q;
   assign bram_addr_out   = addr_q;
   assign bram_data_out   = data_q;
   assign front_buf_out   = front_buf_q;
   assign frame_done_out  = frame_done_q;
   assign swap_out        = swap_q;
   assign resync_out      = resync_q;
   assign frame_count_out = frame_count_q;

endmodule
